// File: rtl/serial_mod_pkg.sv
// Shared types and constants for the serial remainder tracker.
// The optional LSB-first build is selected with SERIAL_MOD_LSB_FIRST_EN.
package serial_mod_pkg;

  localparam int DIVISOR_MIN = 2;
  localparam int DIVISOR_MAX = 255;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  // Smallest width able to hold every remainder 0..divisor-1.
  function automatic int rem_width(input int divisor);
    int w;
    w = 0;
    while ((1 << w) < divisor) w++;
    return w;
  endfunction

endpackage

// File: rtl/serial_mod_step.sv
// One "add then conditional subtract" modular step: sum = (a + b + cin) mod DIVISOR.
// Valid whenever a, b < DIVISOR, so the raw sum is always below 2*DIVISOR.
module serial_mod_step #(
  parameter  int DIVISOR = 5,
  localparam int REM_W   = $clog2(DIVISOR)
) (
  input  logic [REM_W-1:0] a,
  input  logic [REM_W-1:0] b,
  input  logic             cin,
  output logic [REM_W-1:0] sum
);

  localparam logic [REM_W:0] DIV_EXT = (REM_W+1)'(DIVISOR);

  logic [REM_W:0] t;

  // NOTE: every always_comb output gets a value on every path, so no latch can be inferred.
  always_comb begin
    t   = {1'b0, a} + {1'b0, b} + {{REM_W{1'b0}}, cin};
    sum = (t >= DIV_EXT) ? REM_W'(t - DIV_EXT) : t[REM_W-1:0];
  end

endmodule

// File: rtl/serial_mod_detector.sv
// Serial remainder tracker: running value of a framed bit stream mod DIVISOR.
// Define SERIAL_MOD_LSB_FIRST_EN for LSB-first streams (adds a weight register).
module serial_mod_detector
  import serial_mod_pkg::*;
#(
  parameter  int DIVISOR = 5,
  parameter  int CNT_W   = 8,
  localparam int REM_W   = $clog2(DIVISOR)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             in_sof,
  input  logic             in_clear,
  output logic             out_valid,
  output logic [REM_W-1:0] remainder,
  output logic             is_divisible,
  output logic [CNT_W-1:0] bit_cnt
);

  if (DIVISOR < DIVISOR_MIN || DIVISOR > DIVISOR_MAX) begin : g_bad_divisor
    $error("serial_mod_detector: DIVISOR %0d out of legal range", DIVISOR);
  end
  if (rem_width(DIVISOR) != REM_W) begin : g_bad_rem_w
    $error("serial_mod_detector: REM_W %0d inconsistent with DIVISOR", REM_W);
  end

  state_t           state;
  logic             frame_start;
  logic [REM_W-1:0] rem_base;
  logic [REM_W-1:0] rem_next;
  logic [CNT_W-1:0] cnt_next;

  // A bit arriving in IDLE, or flagged sof, starts a fresh frame from remainder 0.
  assign frame_start = (state == IDLE) || in_sof;
  assign rem_base    = frame_start ? '0 : remainder;
  assign cnt_next    = frame_start  ? CNT_W'(1) :
                       (&bit_cnt)   ? bit_cnt   : bit_cnt + CNT_W'(1);

`ifdef SERIAL_MOD_LSB_FIRST_EN
  localparam logic [REM_W-1:0] W_ONE = REM_W'(1);

  logic [REM_W-1:0] weight;
  logic [REM_W-1:0] w_base;
  logic [REM_W-1:0] w_next;
  logic [REM_W-1:0] addend;

  // weight holds 2^k mod DIVISOR for the bit position about to arrive.
  assign w_base = frame_start ? W_ONE : weight;
  assign addend = in_bit ? w_base : '0;

  serial_mod_step #(.DIVISOR(DIVISOR)) u_rem_step (
    .a   (rem_base),
    .b   (addend),
    .cin (1'b0),
    .sum (rem_next)
  );

  serial_mod_step #(.DIVISOR(DIVISOR)) u_wgt_step (
    .a   (w_base),
    .b   (w_base),
    .cin (1'b0),
    .sum (w_next)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || in_clear) weight <= W_ONE;
    else if (in_valid)      weight <= w_next;
  end
`else
  // MSB-first: next = (2*r + bit) mod DIVISOR.
  serial_mod_step #(.DIVISOR(DIVISOR)) u_rem_step (
    .a   (rem_base),
    .b   (rem_base),
    .cin (in_bit),
    .sum (rem_next)
  );
`endif

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      remainder    <= '0;
      is_divisible <= 1'b0;
      bit_cnt      <= '0;
    end else if (in_clear) begin
      state        <= IDLE;
      out_valid    <= 1'b0;
      remainder    <= '0;
      is_divisible <= 1'b0;
      bit_cnt      <= '0;
    end else if (in_valid) begin
      state        <= ACTIVE;
      out_valid    <= 1'b1;
      remainder    <= rem_next;
      is_divisible <= (rem_next == '0);
      bit_cnt      <= cnt_next;
    end else begin
      out_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_mod_detector.sv
// Self-checking bench: three detector instances (D=5, D=3, D=13 with 4-bit counter)
// share one stimulus stream and are compared to a modular-arithmetic reference model.
module tb_serial_mod_detector;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0, in_bit = 1'b0, in_sof = 1'b0, in_clear = 1'b0;

  logic       ov5, div5;
  logic [2:0] rem5;
  logic [7:0] cnt5;
  logic       ov3, div3;
  logic [1:0] rem3;
  logic [7:0] cnt3;
  logic       ov13, div13;
  logic [3:0] rem13;
  logic [3:0] cnt13;

  serial_mod_detector #(.DIVISOR(5), .CNT_W(8)) u_d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .in_clear(in_clear), .out_valid(ov5), .remainder(rem5), .is_divisible(div5), .bit_cnt(cnt5));

  serial_mod_detector #(.DIVISOR(3), .CNT_W(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .in_clear(in_clear), .out_valid(ov3), .remainder(rem3), .is_divisible(div3), .bit_cnt(cnt3));

  serial_mod_detector #(.DIVISOR(13), .CNT_W(4)) u_d13 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_bit(in_bit), .in_sof(in_sof),
    .in_clear(in_clear), .out_valid(ov13), .remainder(rem13), .is_divisible(div13), .bit_cnt(cnt13));

  always #5 clk = ~clk;

  logic        ov_o  [3];
  logic        div_o [3];
  logic [31:0] rem_o [3];
  logic [31:0] cnt_o [3];

  always_comb begin
    ov_o[0] = ov5;  div_o[0] = div5;  rem_o[0] = 32'(rem5);  cnt_o[0] = 32'(cnt5);
    ov_o[1] = ov3;  div_o[1] = div3;  rem_o[1] = 32'(rem3);  cnt_o[1] = 32'(cnt3);
    ov_o[2] = ov13; div_o[2] = div13; rem_o[2] = 32'(rem13); cnt_o[2] = 32'(cnt13);
  end

  localparam int DIV  [3] = '{5, 3, 13};
  localparam int CMAX [3] = '{255, 255, 15};

  // Reference model: value of the frame so far mod D, via plain % arithmetic.
  int m_rem [3], m_cnt [3], m_pow [3];
  bit m_act [3], m_ov [3], m_div [3];

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic model_edge();
    for (int i = 0; i < 3; i++) begin
      if (!rst_n || in_clear) begin
        m_act[i] = 0; m_ov[i] = 0; m_rem[i] = 0; m_cnt[i] = 0; m_div[i] = 0; m_pow[i] = 1;
      end else if (in_valid) begin
        if (!m_act[i] || in_sof) begin
          m_rem[i] = 0; m_cnt[i] = 0; m_pow[i] = 1;
        end
`ifdef SERIAL_MOD_LSB_FIRST_EN
        m_rem[i] = (m_rem[i] + int'(in_bit) * m_pow[i]) % DIV[i];
        m_pow[i] = (2 * m_pow[i]) % DIV[i];
`else
        m_rem[i] = (2 * m_rem[i] + int'(in_bit)) % DIV[i];
`endif
        m_cnt[i] = (m_cnt[i] < CMAX[i]) ? m_cnt[i] + 1 : CMAX[i];
        m_act[i] = 1; m_ov[i] = 1; m_div[i] = (m_rem[i] == 0);
      end else begin
        m_ov[i] = 0;
      end
    end
  endtask

  // Apply one cycle of stimulus at the falling edge; return 1 time unit after the rising edge.
  task automatic drive(input logic v, input logic b, input logic s, input logic c);
    @(negedge clk);
    in_valid = v; in_bit = b; in_sof = s; in_clear = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov_o[i] !== 1'b0 || rem_o[i] !== 32'd0 || div_o[i] !== 1'b0 || cnt_o[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got ov=%0b rem=%0d div=%0b cnt=%0d, want all 0",
                 i, ov_o[i], rem_o[i], div_o[i], cnt_o[i]);
      end
    end
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_msb_frame();
    int exp_r [4];
`ifdef SERIAL_MOD_LSB_FIRST_EN
    exp_r = '{1, 1, 0, 0};
`else
    exp_r = '{1, 2, 0, 0};
`endif
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, (k % 2 == 0) ? 1'b1 : 1'b0, (k == 0) ? 1'b1 : 1'b0, 1'b0);
      n_cmp++;
      if (ov_o[0] !== 1'b1 || rem_o[0] !== 32'(exp_r[k]) || div_o[0] !== (exp_r[k] == 0)
          || cnt_o[0] !== 32'(k + 1)) begin
        n_fail++;
        $display("FAIL frame_d5[%0d]: got ov=%0b rem=%0d div=%0b cnt=%0d, want ov=1 rem=%0d div=%0b cnt=%0d",
                 k, ov_o[0], rem_o[0], div_o[0], cnt_o[0], exp_r[k], exp_r[k] == 0, k + 1);
      end
    end
  endtask

  task automatic test_gaps();
    int   exp_r [4];
    logic bits  [4];
    bits = '{1'b1, 1'b1, 1'b0, 1'b1};
`ifdef SERIAL_MOD_LSB_FIRST_EN
    exp_r = '{1, 0, 0, 2};
`else
    exp_r = '{1, 0, 0, 1};
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, bits[k], (k == 0) ? 1'b1 : 1'b0, 1'b0);
      n_cmp++;
      if (ov_o[1] !== 1'b1 || rem_o[1] !== 32'(exp_r[k]) || cnt_o[1] !== 32'(k + 1)) begin
        n_fail++;
        $display("FAIL gaps_bit[%0d]: got ov=%0b rem=%0d cnt=%0d, want ov=1 rem=%0d cnt=%0d",
                 k, ov_o[1], rem_o[1], cnt_o[1], exp_r[k], k + 1);
      end
      for (int g = 0; g < 2; g++) begin
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (ov_o[1] !== 1'b0 || rem_o[1] !== 32'(exp_r[k]) || cnt_o[1] !== 32'(k + 1)
            || div_o[1] !== (exp_r[k] == 0)) begin
          n_fail++;
          $display("FAIL gaps_hold[%0d.%0d]: got ov=%0b rem=%0d cnt=%0d div=%0b, want ov=0 rem=%0d cnt=%0d",
                   k, g, ov_o[1], rem_o[1], cnt_o[1], div_o[1], exp_r[k], k + 1);
        end
      end
    end
  endtask

  task automatic test_mid_sof();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (rem_o[0] !== 32'd3 || cnt_o[0] !== 32'd2) begin
      n_fail++;
      $display("FAIL mid_sof_pre: got rem=%0d cnt=%0d, want rem=3 cnt=2", rem_o[0], cnt_o[0]);
    end
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++;
    if (ov_o[0] !== 1'b1 || rem_o[0] !== 32'd1 || cnt_o[0] !== 32'd1 || div_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_sof: got ov=%0b rem=%0d cnt=%0d div=%0b, want ov=1 rem=1 cnt=1 div=0",
               ov_o[0], rem_o[0], cnt_o[0], div_o[0]);
    end
  endtask

  task automatic test_clear();
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov_o[i] !== 1'b0 || rem_o[i] !== 32'd0 || div_o[i] !== 1'b0 || cnt_o[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL clear_with_valid[%0d]: got ov=%0b rem=%0d div=%0b cnt=%0d, want all 0",
                 i, ov_o[i], rem_o[i], div_o[i], cnt_o[i]);
      end
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ov_o[0] !== 1'b0 || div_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_idle: got ov=%0b div=%0b, want ov=0 div=0", ov_o[0], div_o[0]);
    end
    // A non-sof bit in IDLE must open a fresh frame.
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (ov_o[0] !== 1'b1 || rem_o[0] !== 32'd0 || div_o[0] !== 1'b1 || cnt_o[0] !== 32'd1) begin
      n_fail++;
      $display("FAIL idle_start: got ov=%0b rem=%0d div=%0b cnt=%0d, want ov=1 rem=0 div=1 cnt=1",
               ov_o[0], rem_o[0], div_o[0], cnt_o[0]);
    end
  endtask

  task automatic test_saturation();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (cnt_o[2] !== 32'd15 || rem_o[2] !== 32'd0 || div_o[2] !== 1'b1 || ov_o[2] !== 1'b1) begin
      n_fail++;
      $display("FAIL saturate_d13: got cnt=%0d rem=%0d div=%0b ov=%0b, want cnt=15 rem=0 div=1 ov=1",
               cnt_o[2], rem_o[2], div_o[2], ov_o[2]);
    end
    n_cmp++;
    if (cnt_o[0] !== 32'd20) begin
      n_fail++;
      $display("FAIL count_d5: got cnt=%0d want 20", cnt_o[0]);
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (ov_o[i] !== 1'b0 || rem_o[i] !== 32'd0 || div_o[i] !== 1'b0 || cnt_o[i] !== 32'd0) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got ov=%0b rem=%0d div=%0b cnt=%0d, want all 0",
                 i, ov_o[i], rem_o[i], div_o[i], cnt_o[i]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 15) == 0,
            $urandom_range(0, 31) == 0);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (ov_o[i] !== m_ov[i] || rem_o[i] !== 32'(m_rem[i]) || div_o[i] !== m_div[i]
            || cnt_o[i] !== 32'(m_cnt[i])) begin
          n_fail++;
          $display("FAIL random[%0d] dut%0d: got ov=%0b rem=%0d div=%0b cnt=%0d, want ov=%0b rem=%0d div=%0b cnt=%0d",
                   n, i, ov_o[i], rem_o[i], div_o[i], cnt_o[i], m_ov[i], m_rem[i], m_div[i], m_cnt[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_msb_frame();
    test_gaps();
    test_mid_sof();
    test_clear();
    test_saturation();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_mod_detector.md
# serial_mod_detector

Parametrised serial remainder tracker: consumes a framed bit stream one bit per valid cycle and reports, one cycle later, the running value of the stream so far modulo DIVISOR, plus a divisibility flag and a saturating bit count. It is the general-divisor successor of the team's fixed divide-by-5 FSM. It adds a valid qualifier, frame start/clear control and a remainder output, and sits downstream of serial deserialiser front-ends as a per-stream integrity/checksum monitor.

## Interface
- DIVISOR, 5: modulus; legal range 2..255.
- CNT_W, 8: width of the bit counter.
- REM_W, $clog2(DIVISOR) (localparam): remainder width.
- clk  input  1  sole clock; all logic on rising edge.
- rst_n  input  1  reset; synchronous, active-low.
- in_valid  input  1  in_bit is consumed this cycle.
- in_bit  input  1  stream bit.
- in_sof  input  1  qualified by in_valid; this bit is the first bit of a new frame.
- in_clear  input  1  abort the frame and return to IDLE; needs no in_valid.
- out_valid  output  1  registered; pulses one cycle after each consumed bit.
- remainder  output  REM_W  value of the frame so far mod DIVISOR.
- is_divisible  output  1  remainder == 0 and state is ACTIVE.
- bit_cnt  output  CNT_W  bits consumed in the current frame; saturates at all-ones.

## Operation
- States: IDLE (no frame open) and ACTIVE.
- IDLE → ACTIVE on the first in_valid, with or without in_sof. A bit received in IDLE always starts a frame, so remainder starts from 0.
- ACTIVE, in_valid and in_sof: restart the frame. This bit is computed from remainder 0 and sets bit_cnt to 1.
- ACTIVE, in_valid and no in_sof: accumulate the bit.
- ACTIVE or IDLE, in_clear: go to IDLE. remainder, bit_cnt and is_divisible go to 0, and out_valid is 0 next cycle.
- in_clear and in_valid in the same cycle: in_clear wins and the bit is dropped.
- MSB-first step, the default: t = 2*r + in_bit, with width REM_W+1. If t >= DIVISOR, the next r is t − DIVISOR; otherwise it is t. There is no general divider or modulo operator.
- in_valid low in ACTIVE: all state holds and out_valid = 0.
- bit_cnt increments on each accepted bit and saturates at 2^CNT_W − 1. Saturation does not affect the remainder.
- is_divisible is 0 in IDLE, even though remainder = 0 there.

## Timing
- Reset (rst_n low at a clock edge): state IDLE; out_valid 0; remainder 0; is_divisible 0; bit_cnt 0. Internal weight register (LSB mode) is 1.
- Reset overrides in_valid, in_sof and in_clear.
- Latency: the bit consumed at edge N is reflected in remainder, is_divisible and bit_cnt after edge N, with out_valid high for that one cycle.
- Throughput: one bit per clock. No backpressure; the block is always ready.
- Outputs hold their last value while out_valid is low.

## Configuration
- SERIAL_MOD_LSB_FIRST_EN defined: the stream is LSB-first.
  - A weight register w (REM_W bits) holds 2^k mod DIVISOR. It resets to 1 on frame start, clear and reset.
  - Each accepted bit does: r = (r + in_bit*w) mod D, then w = (2w) mod D. Both steps use a single conditional subtract.
- SERIAL_MOD_LSB_FIRST_EN undefined: MSB-first only. The weight register is not synthesised.
- Port list is identical in both builds.

## Structure
- Package serial_mod_pkg holds:
  - the state typedef (enum IDLE, ACTIVE);
  - a localparam function computing REM_W checks;
  - the legal-DIVISOR bounds constants, used by an elaboration-time assertion.
- Sub-module serial_mod_step: a combinational "add then conditional subtract" step, parameterised by DIVISOR.
  - MSB mode uses one instance.
  - LSB mode uses two instances: one for the remainder and one for the weight doubling.

## Test plan
- DIVISOR=5, MSB-first, bits 1,0,1,0 with sof on the first bit → remainder 1,2,0,0; is_divisible 0,0,1,1; bit_cnt 1..4.
- DIVISOR=3, bits 1,1,0,1 (13) → remainder 1,0,0,1. Insert idle gaps between the bits → outputs hold and out_valid is 0 during the gaps.
- Mid-frame in_sof: after bits 1,1 (r=3 with D=5), send sof with bit 1 → remainder 1, bit_cnt 1.
- in_clear together with in_valid and bit 1 → the bit is dropped; next cycle state IDLE, remainder 0, is_divisible 0, out_valid 0.
- CNT_W=4, 20 bits of 0 → bit_cnt saturates at 15, remainder stays 0, is_divisible 1. Asserting rst_n low mid-frame → all outputs 0 on the next edge.
- SERIAL_MOD_LSB_FIRST_EN, DIVISOR=5, LSB-first bits 1,0,1 (value 5) → remainder 1,1,0; is_divisible on the third bit.
